// File: rtl/key_stack.sv
// key_stack: last-note-priority keyboard tracker.
// Keeps an ordered stack of held keys (index 0 = oldest, count-1 = newest).
// A released key is removed from the stack, and the output falls back to
// the most recent key that is still held. New presses are queued and pushed
// one per cycle, lowest index first.
module key_stack #(
    parameter int NUM_KEYS          = 24,
    parameter int IDX_W             = 5,
    parameter int DEPTH             = 8,
    parameter int RETRIG_ON_RELEASE = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_KEYS-1:0]          keys,
    output logic [IDX_W-1:0]             key,
    output logic                         press,
    output logic                         trigger,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int CNT_W = $clog2(DEPTH+1);

    // Registered state
    logic [IDX_W-1:0]    stack_reg [DEPTH];
    logic [CNT_W-1:0]    count_reg;
    logic [NUM_KEYS-1:0] pending_reg;
    logic [NUM_KEYS-1:0] prev_reg;
    logic [IDX_W-1:0]    key_reg;
    logic                press_reg;
    logic                trigger_reg;
    logic                overflow_reg;

    // Next-state values
    logic [IDX_W-1:0]    stack_next [DEPTH];
    logic [CNT_W-1:0]    count_next;
    logic [NUM_KEYS-1:0] pending_next;
    logic [IDX_W-1:0]    key_next;
    logic                press_next;
    logic                trigger_next;
    logic                overflow_next;

    // Intermediate values
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] cand;
    logic [NUM_KEYS-1:0] push_mask;
    logic [DEPTH-1:0]    held;
    logic [IDX_W-1:0]    rm_stack [DEPTH];
    logic [IDX_W-1:0]    push_idx;
    logic                push_en;
    int                  kept;

    assign rise = keys & ~prev_reg;
    assign cand = (pending_reg | rise) & keys;

    // An entry survives only if it is valid and its key is still down.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_held
            assign held[gi] = (count_reg > CNT_W'(gi)) && keys[stack_reg[gi]];
        end
    endgenerate

    // Remove released entries, compacting toward the bottom in original order.
    always_comb begin
        rm_stack = '{default: '0};
        kept     = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (held[i]) begin
                rm_stack[kept] = stack_reg[i];
                kept           = kept + 1;
            end
        end
    end

    // Pick the lowest-index pressed-but-not-yet-pushed key for this cycle.
    always_comb begin
        push_idx  = '0;
        push_mask = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                push_idx = IDX_W'(i);
            end
        end
        push_en = |cand;
        if (push_en) begin
            push_mask[push_idx] = 1'b1;
        end
        pending_next = cand & ~push_mask;
    end

    // Push onto the compacted stack, evicting the oldest entry when full,
    // and derive the registered outputs from the resulting top of stack.
    always_comb begin
        stack_next    = rm_stack;
        count_next    = CNT_W'(kept);
        overflow_next = 1'b0;
        key_next      = key_reg;
        trigger_next  = 1'b0;
        if (push_en) begin
            if (kept == DEPTH) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    stack_next[i] = rm_stack[i+1];
                end
                stack_next[DEPTH-1] = push_idx;
                overflow_next       = 1'b1;
            end else begin
                stack_next[kept] = push_idx;
                count_next       = CNT_W'(kept + 1);
            end
            key_next     = push_idx;
            trigger_next = 1'b1;
        end else if (kept > 0) begin
            key_next = rm_stack[kept-1];
            // Fallback to a different held key may optionally retrigger.
            if (RETRIG_ON_RELEASE != 0 && rm_stack[kept-1] != key_reg) begin
                trigger_next = 1'b1;
            end
        end
        press_next = (count_next != '0);
    end

    // State register; keys held through reset are captured in prev so they
    // do not count as fresh presses afterwards.
    always_ff @(posedge clk) begin
        prev_reg <= keys;
        if (!rst_n) begin
            stack_reg    <= '{default: '0};
            count_reg    <= '0;
            pending_reg  <= '0;
            key_reg      <= '0;
            press_reg    <= 1'b0;
            trigger_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            stack_reg    <= stack_next;
            count_reg    <= count_next;
            pending_reg  <= pending_next;
            key_reg      <= key_next;
            press_reg    <= press_next;
            trigger_reg  <= trigger_next;
            overflow_reg <= overflow_next;
        end
    end

    assign key      = key_reg;
    assign press    = press_reg;
    assign trigger  = trigger_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_key_stack.sv
// Directed bench for key_stack: linear stimulus steps, each followed by
// immediate assertions against hand-computed expected outputs.
module tb_key_stack;

    logic        clk;
    logic        rst_n;
    logic [23:0] keys;
    logic [4:0]  key;
    logic        press;
    logic        trigger;
    logic [3:0]  count;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

    key_stack #(
        .NUM_KEYS(24),
        .IDX_W(5),
        .DEPTH(8),
        .RETRIG_ON_RELEASE(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .keys(keys),
        .key(key),
        .press(press),
        .trigger(trigger),
        .count(count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [23:0] k);
        keys = k;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("%s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_key, input int e_press,
                           input int e_trig, input int e_cnt, input int e_ovf);
        chk({tag, ".key"},      int'(key),      e_key);
        chk({tag, ".press"},    int'(press),    e_press);
        chk({tag, ".trigger"},  int'(trigger),  e_trig);
        chk({tag, ".count"},    int'(count),    e_cnt);
        chk({tag, ".overflow"}, int'(overflow), e_ovf);
        $display("step %-10s keys=%06h key=%0d press=%0b trig=%0b count=%0d ovf=%0b",
                 tag, keys, key, press, trigger, count, overflow);
    endtask

    initial begin
        logic [23:0] m;
        // 1: reset with key 2 held; it must not sound until re-pressed
        rst_n = 1'b0;
        apply(24'h000004);
        apply(24'h000004);
        chk_all("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        apply(24'h000004);
        chk_all("held", 0, 0, 0, 0, 0);
        apply(24'h000000);
        chk_all("drop2", 0, 0, 0, 0, 0);
        apply(24'h000004);
        chk_all("repress2", 2, 1, 1, 1, 0);
        apply(24'h000000);
        chk_all("empty", 2, 0, 0, 0, 0);

        // 2: stacked presses and fallback without retrigger
        apply(24'h000020);
        chk_all("p5", 5, 1, 1, 1, 0);
        apply(24'h000220);
        chk_all("p9", 9, 1, 1, 2, 0);
        apply(24'h001220);
        chk_all("p12", 12, 1, 1, 3, 0);
        apply(24'h000220);
        chk_all("r12", 9, 1, 0, 2, 0);
        apply(24'h000020);
        chk_all("r9", 5, 1, 0, 1, 0);
        apply(24'h000000);
        chk_all("r5", 5, 0, 0, 0, 0);
        apply(24'h000020);
        chk_all("re5", 5, 1, 1, 1, 0);
        apply(24'h000000);
        chk_all("clr2", 5, 0, 0, 0, 0);

        // 3: simultaneous presses are pushed lowest index first
        apply(24'h000A01);
        chk_all("m0", 0, 1, 1, 1, 0);
        apply(24'h000A01);
        chk_all("m9", 9, 1, 1, 2, 0);
        apply(24'h000A01);
        chk_all("m11", 11, 1, 1, 3, 0);
        apply(24'h000A01);
        chk_all("mhold", 11, 1, 0, 3, 0);
        apply(24'h000000);
        chk_all("clr3", 11, 0, 0, 0, 0);
        // a key released before its queued push never appears
        apply(24'h000003);
        chk_all("q0", 0, 1, 1, 1, 0);
        apply(24'h000001);
        chk_all("qdrop1", 0, 1, 0, 1, 0);
        apply(24'h000001);
        chk_all("qhold", 0, 1, 0, 1, 0);
        apply(24'h000000);
        chk_all("clr3b", 0, 0, 0, 0, 0);

        // 4: overflow evicts the oldest entry
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = 1'b1;
            apply(m);
            chk_all($sformatf("fill%0d", i), i, 1, 1, i + 1, 0);
        end
        m[8] = 1'b1;
        apply(m);
        chk_all("ovf", 8, 1, 1, 8, 1);
        m[0] = 1'b0;
        apply(m);
        chk_all("rel_evict", 8, 1, 0, 8, 0);
        m[8] = 1'b0;
        apply(m);
        chk_all("rel8", 7, 1, 0, 7, 0);
        apply(24'h000000);
        chk_all("clr4", 7, 0, 0, 0, 0);

        // 5: release top and press another in the same cycle
        apply(24'h000004);
        chk_all("s2", 2, 1, 1, 1, 0);
        apply(24'h000084);
        chk_all("s7", 7, 1, 1, 2, 0);
        apply(24'h00000C);
        chk_all("swap3", 3, 1, 1, 2, 0);
        apply(24'h000000);
        chk_all("clr5", 3, 0, 0, 0, 0);

        // 6: reset mid-operation with keys held
        apply(24'h000010);
        chk_all("h4", 4, 1, 1, 1, 0);
        apply(24'h000050);
        chk_all("h6", 6, 1, 1, 2, 0);
        rst_n = 1'b0;
        apply(24'h000050);
        chk_all("mreset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        apply(24'h000050);
        chk_all("post1", 0, 0, 0, 0, 0);
        apply(24'h000050);
        chk_all("post2", 0, 0, 0, 0, 0);
        apply(24'h000040);
        chk_all("post_r4", 0, 0, 0, 0, 0);
        apply(24'h000050);
        chk_all("post_p4", 4, 1, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
